// File: rtl/cr_kme_fifo_rr_arb.sv
// Round-robin, packet-locked arbiter feeding the KME staging FIFO write port.
// Zero-latency handshake; a lock watchdog frees an owner that goes quiet mid-packet.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | no packet open; round-robin search from rr_q
// ST_LOCKED | multi-beat packet open on owner_q; other requesters ignored
module cr_kme_fifo_rr_arb #(
   parameter int N_REQ    = 4,
   parameter int DATA_W   = 611,
   parameter int LOCK_TMO = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_REQ-1:0]         req_valid,
   input  logic [N_REQ*DATA_W-1:0]  req_data,
   input  logic [N_REQ-1:0]         req_eop,
   output logic [N_REQ-1:0]         req_ack,
   output logic [DATA_W-1:0]        fifo_in,
   output logic                     fifo_in_valid,
   input  logic                     fifo_in_stall,
   output logic [2:0]               grant_id,
   output logic                     locked,
   output logic                     lock_tmo_err
);

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [16:0] TMO_LIM = 17'(LOCK_TMO - 1);

   typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

   state_t         state_q, state_d;
   logic [IW-1:0]  owner_q, owner_d;
   logic [IW-1:0]  rr_q, rr_d;
   logic [IW-1:0]  grant_q, grant_d;
   logic [15:0]    idle_q, idle_d;
   logic           tmo_q, tmo_d;

   logic [IW-1:0]  sel, sel_inc, cand;
   logic           found, xfer;
   logic [16:0]    idle_inc;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         owner_q <= '0;
         rr_q    <= '0;
         grant_q <= '0;
         idle_q  <= '0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         rr_q    <= rr_d;
         grant_q <= grant_d;
         idle_q  <= idle_d;
         tmo_q   <= tmo_d;
      end
   end

   // Select and write path: rotating priority in IDLE, owner pinned in LOCKED.
   always_comb begin
      found = 1'b0;
      sel   = rr_q;
      cand  = '0;
      if (state_q == ST_LOCKED) begin
         sel   = owner_q;
         found = req_valid[owner_q];
      end else begin
         for (int k = 0; k < N_REQ; k++) begin
            cand = IW'((int'(rr_q) + k) % N_REQ);
            if (!found && req_valid[cand]) begin
               found = 1'b1;
               sel   = cand;
            end
         end
      end
      sel_inc       = (sel == IW'(N_REQ - 1)) ? '0 : sel + IW'(1);
      xfer          = found & ~fifo_in_stall & rst_n;
      fifo_in_valid = xfer;
      req_ack       = '0;
      req_ack[sel]  = xfer;
      fifo_in       = req_data[int'(sel)*DATA_W +: DATA_W];
   end

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      rr_d     = rr_q;
      grant_d  = grant_q;
      idle_d   = idle_q;
      tmo_d    = 1'b0;
      idle_inc = {1'b0, idle_q} + 17'd1;
      case (state_q)
         ST_IDLE: begin
            if (xfer) begin
               grant_d = sel;
               if (req_eop[sel]) begin
                  rr_d = sel_inc;
               end else begin
                  state_d = ST_LOCKED;
                  owner_d = sel;
                  idle_d  = '0;
               end
            end
         end
         ST_LOCKED: begin
            if (xfer) begin
               idle_d = '0;
               if (req_eop[owner_q]) begin
                  state_d = ST_IDLE;
                  rr_d    = sel_inc;
               end
            end else if (!req_valid[owner_q]) begin
               // Only an absent owner ages the lock; a stalled owner holds it.
               idle_d = idle_inc[15:0];
               if (idle_inc >= TMO_LIM) begin
                  state_d = ST_IDLE;
                  rr_d    = sel_inc;
                  tmo_d   = 1'b1;
                  idle_d  = '0;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign grant_id     = 3'(grant_q);
   assign locked       = (state_q == ST_LOCKED);
   assign lock_tmo_err = tmo_q;

endmodule

// File: tb/tb_cr_kme_fifo_rr_arb.sv
// Bench for cr_kme_fifo_rr_arb: directed scenarios then randomized sources,
// all checked cycle by cycle against a behavioural arbitration model.
module tb_cr_kme_fifo_rr_arb;
   localparam int N   = 4;
   localparam int DW  = 16;
   localparam int TMO = 4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req_valid, req_eop, req_ack;
   logic [N*DW-1:0] req_data;
   logic [DW-1:0]   fifo_in;
   logic            fifo_in_valid, fifo_in_stall;
   logic [2:0]      grant_id;
   logic            locked, lock_tmo_err;

   always #5 clk = ~clk;

   cr_kme_fifo_rr_arb #(.N_REQ(N), .DATA_W(DW), .LOCK_TMO(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
      .req_eop(req_eop), .req_ack(req_ack), .fifo_in(fifo_in),
      .fifo_in_valid(fifo_in_valid), .fifo_in_stall(fifo_in_stall),
      .grant_id(grant_id), .locked(locked), .lock_tmo_err(lock_tmo_err)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      total++;
      if (obs !== want) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", tag, obs, want);
      end
   endtask

   // Model: packet owner (or -1), rotation start, idle age, last grant, timeout pulse.
   int  m_owner = -1;
   int  m_ptr = 0, m_idle = 0, m_gid = 0, m_err = 0;
   bit  m_known = 0;
   int  exp_seq[N];
   int  seq[N];
   int  last_ack, last_err;
   bit  pk_open = 0;
   int  pk_id = 0;

   task automatic cyc(input logic [N-1:0] v, input logic [N-1:0] e, input logic st, input logic rs);
      int ex, oa, id;
      @(negedge clk);
      rst_n = rs; req_valid = v; req_eop = e; fifo_in_stall = st;
      for (int i = 0; i < N; i++) req_data[i*DW +: DW] = {4'(i), 12'(seq[i])};
      #1;
      if (m_known) begin
         chk("grant_id", grant_id, m_gid);
         chk("locked", locked, (m_owner >= 0));
         chk("tmo_err", lock_tmo_err, m_err);
      end
      last_err = lock_tmo_err;
      if (lock_tmo_err || !rs) pk_open = 0;
      ex = -1;
      if (rs && !st) begin
         if (m_owner >= 0) begin
            if (v[m_owner]) ex = m_owner;
         end else begin
            for (int k = N - 1; k >= 0; k--)
               if (v[(m_ptr + k) % N]) ex = (m_ptr + k) % N;
         end
      end
      chk("ack", req_ack, (ex >= 0) ? (1 << ex) : 0);
      chk("wen", fifo_in_valid, (ex >= 0));
      chk("wen_while_stall", fifo_in_valid & fifo_in_stall, 0);
      oa = -1;
      for (int i = 0; i < N; i++) if (req_ack[i]) oa = i;
      last_ack = oa;
      if (ex >= 0) begin
         chk("data", fifo_in, {4'(ex), 12'(exp_seq[ex])});
         exp_seq[ex] = (exp_seq[ex] + 1) % 4096;
      end
      if (oa >= 0) seq[oa] = (seq[oa] + 1) % 4096;
      if (fifo_in_valid === 1'b1) begin
         id = int'(fifo_in[15:12]);
         if (pk_open) chk("contiguous", id, pk_id);
         pk_open = (id < N) ? !e[id] : 1'b0;
         pk_id   = id;
      end
      m_err = 0;
      if (!rs) begin
         m_owner = -1; m_ptr = 0; m_idle = 0; m_gid = 0; m_known = 1;
      end else if (ex >= 0) begin
         m_gid  = ex;
         m_idle = 0;
         if (e[ex]) begin
            m_owner = -1;
            m_ptr   = (ex + 1) % N;
         end else begin
            m_owner = ex;
         end
      end else if (m_owner >= 0 && !v[m_owner]) begin
         m_idle++;
         if (m_idle >= TMO - 1) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_err   = 1;
         end
      end
   endtask

   logic [N-1:0] sv, se;
   int sb[N], sl[N];

   initial begin
      rst_n = 1'b0; req_valid = '0; req_eop = '0; fifo_in_stall = 1'b0; req_data = '0;
      for (int i = 0; i < N; i++) begin seq[i] = 0; exp_seq[i] = 0; sb[i] = 0; sl[i] = 1; end

      // reset: all requesting, nothing may be accepted
      cyc(4'hF, 4'hF, 1'b0, 1'b0);
      cyc(4'hF, 4'hF, 1'b0, 1'b0);

      // fairness
      for (int i = 0; i < 8; i++) begin
         cyc(4'hF, 4'hF, 1'b0, 1'b1);
         chk("fair_order", last_ack, i % 4);
      end

      // packet lock: req0 3 beats, req1 waiting
      cyc(4'b0011, 4'b0010, 1'b0, 1'b1); chk("lock_b0", last_ack, 0);
      cyc(4'b0011, 4'b0010, 1'b0, 1'b1); chk("lock_b1", last_ack, 0); chk("lock_held", locked, 1);
      cyc(4'b0011, 4'b0011, 1'b0, 1'b1); chk("lock_b2", last_ack, 0); chk("lock_held", locked, 1);
      cyc(4'b0011, 4'b0010, 1'b0, 1'b1); chk("lock_next", last_ack, 1);

      // backpressure mid-packet on owner 2
      cyc(4'b0100, 4'b0000, 1'b0, 1'b1); chk("bp_start", last_ack, 2);
      for (int i = 0; i < 5; i++) begin
         cyc(4'b0100, 4'b0000, 1'b1, 1'b1);
         chk("bp_no_ack", last_ack, -1);
         chk("bp_no_tmo", last_err, 0);
      end
      cyc(4'b0100, 4'b0100, 1'b0, 1'b1); chk("bp_resume", last_ack, 2);

      // watchdog on owner 2
      cyc(4'b0010, 4'b0010, 1'b0, 1'b1); chk("wd_pre", last_ack, 1);
      cyc(4'b0100, 4'b0000, 1'b0, 1'b1); chk("wd_lock", last_ack, 2);
      for (int k = 1; k <= 5; k++) begin
         cyc(4'b0000, 4'b0000, 1'b0, 1'b1);
         chk("wd_err", last_err, (k == 4));
      end
      cyc(4'hF, 4'hF, 1'b0, 1'b1); chk("wd_next", last_ack, 3);

      // reset while locked on owner 1
      cyc(4'b0010, 4'b0000, 1'b0, 1'b1); chk("rst_lock", last_ack, 1);
      cyc(4'b0011, 4'b0011, 1'b0, 1'b0); chk("rst_no_ack", last_ack, -1);
      cyc(4'b0011, 4'b0011, 1'b0, 1'b1);
      chk("rst_locked", locked, 0);
      chk("rst_grant", grant_id, 0);
      chk("rst_search", last_ack, 0);

      // randomized sources with mid-packet pauses and random stall
      sv = '0; se = '0;
      for (int c = 0; c < 10000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!sv[i]) begin
               if ($urandom_range(0, 9) < 4) begin
                  sv[i] = 1'b1;
                  if (sb[i] == 0) sl[i] = int'($urandom_range(1, 4));
               end
            end else if (sb[i] != 0 && $urandom_range(0, 99) < 3) begin
               sv[i] = 1'b0;
            end
            se[i] = (sb[i] == sl[i] - 1);
         end
         cyc(sv, se, ($urandom_range(0, 3) == 0), 1'b1);
         if (last_ack >= 0) begin
            sb[last_ack]++;
            if (sb[last_ack] >= sl[last_ack]) sb[last_ack] = 0;
            sv[last_ack] = 1'($urandom_range(0, 1));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
